flag_branch_unit: RTL and testbench
===================================

// Module: flag_branch_unit
// PURPOSE
//  Execute-stage consumer of the ALU wrapper outputs (alu_out, flags[1:0]).
//  Holds the architectural flag register, updating it from flag-setting ops.
//  Resolves conditional branches against the committed flags, one cycle registered.
//  Saves flags on interrupt entry and restores them on RETI through a small LIFO.
// PARAMETERS
//  FLAG_STACK_DEPTH  4  number of saved flag entries (>=2, power of 2)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  instr_valid_i  in   1   instruction present in execute this cycle
//  stall_i        in   1   pipeline stall; freezes all state and outputs
//  opcode_i       in   5   instruction opcode (cpu_pkg encodings)
//  cond_i         in   3   branch condition, used only when opcode_i==BR
//  alu_flags_i    in   2   ALU flags this cycle: [1]=N, [0]=Z
//  int_ack_i      in   1   interrupt taken; push current flags
//  flags_o        out  2   architectural flags {N,Z}
//  br_valid_o     out  1   branch resolved (registered, 1-cycle pulse)
//  br_taken_o     out  1   branch outcome, qualified by br_valid_o
//  stack_level_o  out  $clog2(FLAG_STACK_DEPTH)+1  occupied stack entries
//  stack_err_o    out  1   sticky overflow/underflow flag
// BEHAVIOUR
//  - Reset (async): flags_o=2'b00, br_valid_o=0, br_taken_o=0, stack empty,
//    stack_level_o=0, stack_err_o=0. Reset mid-operation discards stack contents.
//  - stall_i=1: no register updates; br_valid_o holds its previous value.
//  - Effective op = instr_valid_i & ~stall_i. Non-effective cycles: br_valid_o<=0.
//  - Flag update, next edge: flags<=alu_flags_i for ADD,ADDI,SUB,SUBI,MUL,DIV,AND,
//    ANDI,OR,ORI,NOT,XOR,XORI,CMP. LD,ST,MOVEH,MOVEL,CALL,RET,BR leave flags unchanged.
//  - BR = 5'b10100. cond: 000 EQ(Z), 001 NE(~Z), 010 LT(N), 011 GT(~N&~Z),
//    100 LE(N|Z), 101 GE(~N), 110 ALWAYS, 111 NEVER.
//  - Branch evaluated against flags_o as committed before this cycle's edge.
//    br_valid_o/br_taken_o asserted the cycle after BR is presented (latency 1).
//  - Back-to-back CMP then BR: BR sees the CMP result, since flags were
//    committed on the prior edge.
//  - int_ack_i (ignores instr_valid_i, honours stall_i): push flags_o; level+1.
//  - RETI effective: pop top into flags; level-1.
//  - Push when full: push dropped, contents kept, stack_err_o<=1.
//  - Pop when empty: flags unchanged, stack_err_o<=1.
//  - Same-cycle int_ack_i and RETI: flags<=top, stack and level unchanged.
//    When empty: flags unchanged, stack_err_o<=1.
//  - Same-cycle flag-setting op and int_ack_i: push pre-update flags, then
//    apply the ALU flags.
//  - stack_err_o clears only on reset.
// CONFIGURATION
//  FLAG_STACK_EN defined: LIFO of FLAG_STACK_DEPTH entries, as above.
//  FLAG_STACK_EN undefined: single shadow register.
//    - int_ack_i overwrites the shadow; RETI restores it.
//    - stack_level_o = 0/1 valid bit; stack_err_o tied 0.
//    - Nested interrupts lose the older save.
// STRUCTURE
//  cpu_pkg: opcode localparams (incl. BR, RETI), cond_e enum, FLAG_N/FLAG_Z indices.
//  Sub-module flag_stack: push/pop/level/err LIFO, instantiated under FLAG_STACK_EN.
//  Top level: flag register, op decode, branch evaluate, output registers.
// TESTING
//  1 Reset with alu_flags_i=2'b11 on input -> flags_o=00, br_valid_o=0, level=0.
//  2 CMP flags=01, next cycle BR cond=000 -> br_valid_o=1, br_taken_o=1 one cycle later.
//    BR cond=001 -> taken=0.
//  3 LD with alu_flags_i=10 after flags=01 -> flags_o stays 01.
//    BR cond=011 -> taken=0; BR cond=100 -> taken=1.
//  4 flags=10; int_ack; SUB flags=01; RETI -> flags_o=10, level 1->0, err=0.
//  5 Depth 4: five int_acks -> level=4, stack_err_o=1.
//    Five RETIs -> 4 pops in LIFO order, 5th leaves flags, err stays 1.
//  6 BR with stall_i=1 for 3 cycles -> no br_valid_o pulse until stall drops.
//    rst_n low mid-stack -> level=0, flags=00 asynchronously.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// cpu_pkg: opcode encodings, branch condition enum and flag bit indices
// shared by the flag/branch unit and anything that drives it.
package cpu_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_SUBI  = 5'b00011;
  localparam logic [4:0] OP_MUL   = 5'b00100;
  localparam logic [4:0] OP_DIV   = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b00110;
  localparam logic [4:0] OP_ANDI  = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_ORI   = 5'b01001;
  localparam logic [4:0] OP_NOT   = 5'b01010;
  localparam logic [4:0] OP_XOR   = 5'b01011;
  localparam logic [4:0] OP_XORI  = 5'b01100;
  localparam logic [4:0] OP_CMP   = 5'b01101;
  localparam logic [4:0] OP_LD    = 5'b01110;
  localparam logic [4:0] OP_ST    = 5'b01111;
  localparam logic [4:0] OP_MOVEH = 5'b10000;
  localparam logic [4:0] OP_MOVEL = 5'b10001;
  localparam logic [4:0] OP_CALL  = 5'b10010;
  localparam logic [4:0] OP_RET   = 5'b10011;
  localparam logic [4:0] OP_BR    = 5'b10100;
  localparam logic [4:0] OP_RETI  = 5'b10101;

  // Bit positions inside the {N,Z} flag word
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    COND_EQ = 3'b000,
    COND_NE = 3'b001,
    COND_LT = 3'b010,
    COND_GT = 3'b011,
    COND_LE = 3'b100,
    COND_GE = 3'b101,
    COND_AL = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  // Arithmetic/logic ops commit the ALU flags; moves, memory, control do not.
  function automatic logic is_flag_setting(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV, OP_AND, OP_ANDI,
      OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI, OP_CMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Execute-stage bundle between the issue side and the flag/branch unit.
// master drives instruction/ALU inputs, slave is the flag/branch unit.
interface flag_branch_unit_if #(
  parameter int FLAG_STACK_DEPTH = 4
);
  localparam int LW = $clog2(FLAG_STACK_DEPTH) + 1;

  logic          instr_valid_i;
  logic          stall_i;
  logic [4:0]    opcode_i;
  logic [2:0]    cond_i;
  logic [1:0]    alu_flags_i;
  logic          int_ack_i;
  logic [1:0]    flags_o;
  logic          br_valid_o;
  logic          br_taken_o;
  logic [LW-1:0] stack_level_o;
  logic          stack_err_o;

  modport master (
    output instr_valid_i, stall_i, opcode_i, cond_i, alu_flags_i, int_ack_i,
    input  flags_o, br_valid_o, br_taken_o, stack_level_o, stack_err_o
  );

  modport slave (
    input  instr_valid_i, stall_i, opcode_i, cond_i, alu_flags_i, int_ack_i,
    output flags_o, br_valid_o, br_taken_o, stack_level_o, stack_err_o
  );

endinterface

// File: rtl/flag_branch_unit_flag_stack.sv
// flag_stack: small LIFO of saved {N,Z} words for interrupt entry/return.
// A simultaneous push and pop leaves the stack untouched (the caller reads
// top_o); any pop or push+pop on empty, or push on full, sets the sticky err.
module flag_stack #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [1:0]    din_i,
  output logic [1:0]    top_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o,
  output logic          err_o
);
  localparam int PW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [LW-1:0] level_q;
  logic          err_q;
  logic          full;
  logic [LW-1:0] top_lvl;
  logic [PW-1:0] top_idx;

  assign full    = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign top_lvl = level_q - LW'(1);
  assign top_idx = top_lvl[PW-1:0];
  assign top_o   = mem[top_idx];
  assign level_o = level_q;
  assign err_o   = err_q;

  // Occupancy and sticky error; reset discards the contents by emptying
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      err_q   <= 1'b0;
    end else if (push_i && pop_i) begin
      if (empty_o) err_q <= 1'b1;
    end else if (push_i) begin
      if (full) err_q <= 1'b1;
      else      level_q <= level_q + LW'(1);
    end else if (pop_i) begin
      if (empty_o) err_q <= 1'b1;
      else         level_q <= level_q - LW'(1);
    end
  end

  // Entry storage; written only on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (push_i && !pop_i && !full) mem[level_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural {N,Z} register, registered branch resolve
// and interrupt flag save/restore.
// Build option FLAG_STACK_EN: when defined, saves go to a FLAG_STACK_DEPTH
// deep LIFO (flag_stack); otherwise a single shadow register is used and
// nested interrupts overwrite the older save.
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int FLAG_STACK_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  flag_branch_unit_if.slave bus
);
  localparam int LW = $clog2(FLAG_STACK_DEPTH) + 1;

  function automatic logic cond_met(input cond_e c, input logic [1:0] f);
    logic n;
    logic z;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    case (c)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_LT: return n;
      COND_GT: return ~n & ~z;
      COND_LE: return n | z;
      COND_GE: return ~n;
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic          eff_p0;
  logic          push_p0;
  logic          pop_p0;
  logic          is_br_p0;
  logic          fset_p0;
  logic [1:0]    flags_q;
  logic [1:0]    flags_d;
  logic [1:0]    restore_flags;
  logic          restore_ok;
  logic          vld_p1;
  logic          taken_p1;
  logic [LW-1:0] level;
  logic          err;

  // Stall masks every state change, including interrupt saves
  assign eff_p0   = bus.instr_valid_i & ~bus.stall_i;
  assign push_p0  = bus.int_ack_i & ~bus.stall_i;
  assign pop_p0   = eff_p0 & (bus.opcode_i == OP_RETI);
  assign is_br_p0 = eff_p0 & (bus.opcode_i == OP_BR);
  assign fset_p0  = eff_p0 & is_flag_setting(bus.opcode_i);

`ifdef FLAG_STACK_EN
  logic stk_empty;

  flag_stack #(
    .DEPTH (FLAG_STACK_DEPTH),
    .LW    (LW)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_p0),
    .pop_i   (pop_p0),
    .din_i   (flags_q),
    .top_o   (restore_flags),
    .empty_o (stk_empty),
    .level_o (level),
    .err_o   (err)
  );

  assign restore_ok = ~stk_empty;
`else
  logic [1:0] shadow_q;
  logic       shadow_vld;

  // Shadow valid bit: set by a save, cleared by a restore, kept on save+restore
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    shadow_vld <= 1'b0;
    else if (push_p0 && !pop_p0)   shadow_vld <= 1'b1;
    else if (pop_p0 && !push_p0)   shadow_vld <= 1'b0;
  end

  // Shadow contents: each save overwrites the previous one
  always_ff @(posedge clk) begin
    if (push_p0 && !pop_p0) shadow_q <= flags_q;
  end

  assign restore_flags = shadow_q;
  assign restore_ok    = shadow_vld;
  assign level         = {{(LW-1){1'b0}}, shadow_vld};
  assign err           = 1'b0;
`endif

  // Next flags: RETI restores saved flags, flag-setting ops take the ALU flags.
  // A save in the same cycle already captured the pre-update flags_q.
  always_comb begin
    flags_d = flags_q;
    if (pop_p0) begin
      if (restore_ok) flags_d = restore_flags;
    end else if (fset_p0) begin
      flags_d = bus.alu_flags_i;
    end
  end

  // Architectural flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 2'b00;
    else        flags_q <= flags_d;
  end

  // ---- stage p0 -> p1: branch resolved against flags committed before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      taken_p1 <= 1'b0;
    end else if (!bus.stall_i) begin
      vld_p1   <= is_br_p0;
      taken_p1 <= is_br_p0 & cond_met(cond_e'(bus.cond_i), flags_q);
    end
  end

  assign bus.flags_o       = flags_q;
  assign bus.br_valid_o    = vld_p1;
  assign bus.br_taken_o    = taken_p1;
  assign bus.stack_level_o = level;
  assign bus.stack_err_o   = err;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: the driver updates a queue-based
// reference model each cycle and pushes the expected outputs; a monitor pops
// and compares after every rising edge.
module tb_flag_branch_unit;
  import cpu_pkg::*;

  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flag_branch_unit_if #(.FLAG_STACK_DEPTH(D)) bus ();

  flag_branch_unit #(.FLAG_STACK_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]    flags;
    logic          bv;
    logic          bt;
    logic [LW-1:0] lvl;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] m_flags;
  logic       m_bv, m_bt, m_err;
  logic [1:0] m_stk[$];
  logic [1:0] m_sh;
  logic       m_shv;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic taken(input logic [2:0] c, input logic [1:0] f);
    logic n, z;
    n = f[1];
    z = f[0];
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n;
      3'd3: return !n && !z;
      3'd4: return n || z;
      3'd5: return !n;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 2'b00;
    m_bv = 1'b0;
    m_bt = 1'b0;
    m_err = 1'b0;
    m_stk.delete();
    m_sh = 2'b00;
    m_shv = 1'b0;
  endtask

  function automatic logic [LW-1:0] model_level();
`ifdef FLAG_STACK_EN
    return LW'(m_stk.size());
`else
    return LW'(m_shv);
`endif
  endfunction

  task automatic model_apply(input logic iv, input logic st, input logic [4:0] op,
                             input logic [2:0] cd, input logic [1:0] alu, input logic ia);
    logic [1:0] nf;
    logic push, pop;
    if (st) return;
    nf   = m_flags;
    push = ia;
    pop  = iv && (op == OP_RETI);
    m_bv = iv && (op == OP_BR);
    m_bt = m_bv && taken(cd, m_flags);
`ifdef FLAG_STACK_EN
    if (push && pop) begin
      if (m_stk.size() > 0) nf = m_stk[$];
      else m_err = 1'b1;
    end else if (push) begin
      if (m_stk.size() == D) m_err = 1'b1;
      else m_stk.push_back(m_flags);
    end else if (pop) begin
      if (m_stk.size() > 0) nf = m_stk.pop_back();
      else m_err = 1'b1;
    end
`else
    if (push && pop) begin
      if (m_shv) nf = m_sh;
    end else if (push) begin
      m_sh = m_flags;
      m_shv = 1'b1;
    end else if (pop) begin
      if (m_shv) begin
        nf = m_sh;
        m_shv = 1'b0;
      end
    end
`endif
    if (iv && (op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV, OP_AND,
                          OP_ANDI, OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI, OP_CMP}))
      nf = alu;
    m_flags = nf;
  endtask

  task automatic set_idle();
    bus.instr_valid_i = 1'b0;
    bus.stall_i       = 1'b0;
    bus.opcode_i      = OP_LD;
    bus.cond_i        = 3'd0;
    bus.alu_flags_i   = 2'b00;
    bus.int_ack_i     = 1'b0;
  endtask

  task automatic step(input logic iv, input logic st, input logic [4:0] op,
                      input logic [2:0] cd, input logic [1:0] alu, input logic ia);
    exp_t e;
    @(negedge clk);
    bus.instr_valid_i = iv;
    bus.stall_i       = st;
    bus.opcode_i      = op;
    bus.cond_i        = cd;
    bus.alu_flags_i   = alu;
    bus.int_ack_i     = ia;
    model_apply(iv, st, op, cd, alu, ia);
    e.flags = m_flags;
    e.bv    = m_bv;
    e.bt    = m_bt;
    e.lvl   = model_level();
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  // Assert reset asynchronously between edges once the scoreboard has drained
  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    set_idle();
    #1;
    model_reset();
    check({tag, "_flags"}, 8'(bus.flags_o), 8'h00);
    check({tag, "_brv"},   8'(bus.br_valid_o), 8'h00);
    check({tag, "_level"}, 8'(bus.stack_level_o), 8'h00);
    check({tag, "_err"},   8'(bus.stack_err_o), 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs with the oldest expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("flags", 8'(bus.flags_o), 8'(e.flags));
        check("br_valid", 8'(bus.br_valid_o), 8'(e.bv));
        if (e.bv) check("br_taken", 8'(bus.br_taken_o), 8'(e.bt));
        check("level", 8'(bus.stack_level_o), 8'(e.lvl));
        check("err", 8'(bus.stack_err_o), 8'(e.err));
      end
    end
  end

  initial begin
    logic [4:0] op;
    int waited;
    rst_n = 1'b0;
    set_idle();
    bus.instr_valid_i = 1'b1;
    bus.opcode_i      = OP_ADD;
    bus.alu_flags_i   = 2'b11;
    model_reset();
    #12;
    check("rst_flags", 8'(bus.flags_o), 8'h00);
    check("rst_brv",   8'(bus.br_valid_o), 8'h00);
    check("rst_brt",   8'(bus.br_taken_o), 8'h00);
    check("rst_level", 8'(bus.stack_level_o), 8'h00);
    check("rst_err",   8'(bus.stack_err_o), 8'h00);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Compare then branch on the fresh flags
    step(1, 0, OP_CMP, 3'd0, 2'b01, 0);
    step(1, 0, OP_BR,  3'd0, 2'b00, 0);
    step(1, 0, OP_BR,  3'd1, 2'b00, 0);
    // Non-flag op keeps flags
    step(1, 0, OP_LD,  3'd0, 2'b10, 0);
    step(1, 0, OP_BR,  3'd3, 2'b11, 0);
    step(1, 0, OP_BR,  3'd4, 2'b11, 0);
    step(0, 0, OP_LD,  3'd0, 2'b00, 0);
    // Save, clobber, restore
    step(1, 0, OP_ADD, 3'd0, 2'b10, 0);
    step(0, 0, OP_LD,  3'd0, 2'b00, 1);
    step(1, 0, OP_SUB, 3'd0, 2'b01, 0);
    step(1, 0, OP_RETI, 3'd0, 2'b00, 0);
    step(1, 0, OP_BR,  3'd2, 2'b00, 0);
    // Five saves with flag updates alongside, then five restores
    for (int i = 0; i < 5; i++) step(1, 0, OP_XOR, 3'd0, 2'(i + 1), 1);
    for (int i = 0; i < 5; i++) step(1, 0, OP_RETI, 3'd0, 2'b11, 0);
    // Same-cycle save and restore
    step(0, 0, OP_LD,   3'd0, 2'b00, 1);
    step(1, 0, OP_ADD,  3'd0, 2'b11, 0);
    step(1, 0, OP_RETI, 3'd0, 2'b00, 1);
    // Branch held under stall
    step(1, 0, OP_AND, 3'd0, 2'b00, 0);
    for (int i = 0; i < 3; i++) step(1, 1, OP_BR, 3'd6, 2'b11, 1);
    step(1, 0, OP_BR, 3'd6, 2'b00, 0);
    step(1, 0, OP_BR, 3'd5, 2'b00, 0);
    step(1, 1, OP_ADD, 3'd0, 2'b11, 0);
    step(0, 0, OP_LD, 3'd0, 2'b00, 0);
    // Reset with saved entries
    step(1, 0, OP_OR, 3'd0, 2'b10, 1);
    step(0, 0, OP_LD, 3'd0, 2'b00, 1);
    async_reset_check("midrst");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) op = ($urandom_range(0, 1) == 0) ? OP_BR : OP_RETI;
      else op = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), op,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
      if (i == 300) async_reset_check("rndrst");
    end
    set_idle();

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    check("drain", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
